seg7_scan_controller: RTL and testbench

- Time-multiplexes one shared 7-segment BCD decoder across NUM_DIGITS common-anode digits of the digital clock display.
- Sits between the timekeeping counters (HH:MM:SS BCD) and the decoder/anode pins.
- Per digit: drives the digit's BCD code and one active-low anode, with a blanking gap between digits to prevent ghosting.
- Double-buffers incoming time values and commits them only at a frame boundary, so a display frame never mixes old and new digits.

---
 rtl/seg7_scan_controller.sv | 186 ++++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
//   Time-multiplexes one shared 7-segment BCD decoder across NUM_DIGITS
//   common-anode digits. Each digit slot is REFRESH_DIV cycles long:
//   BLANK_CYCLES with every anode off, then SHOW with the digit's anode on.
//   Incoming digits are double-buffered, and the shadow copy is committed
//   only at a frame boundary, so one frame never mixes old and new digits.
//
//   Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to keep leading
//   zeros dark. Suppression runs from the MSB down, stops at the first
//   non-zero digit or at the first digit with its dp bit set, and never
//   applies to digit 0.
//
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   enable        scan enable; low forces the display dark and returns to IDLE
//   digits_in     BCD digits, digit 0 in [3:0]
//   dp_in         decimal point per digit, 1 = lit
//   blank_mask    1 = keep that digit dark
//   update_req    1-cycle strobe: capture digits_in/dp_in into the shadow
//   update_ack    1-cycle pulse when the shadow is committed to active
//   bcd_out       BCD code to the shared decoder
//   dp_out        active-low decimal point
//   an            active-low anodes, at most one bit low
//   digit_idx     index of the digit currently selected
//   frame_done    1-cycle pulse on the first cycle of a new frame
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [4*NUM_DIGITS-1:0]         digits_in,
  input  logic [NUM_DIGITS-1:0]           dp_in,
  input  logic [NUM_DIGITS-1:0]           blank_mask,
  input  logic                            update_req,
  output logic                            update_ack,
  output logic [3:0]                      bcd_out,
  output logic                            dp_out,
  output logic [NUM_DIGITS-1:0]           an,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  // With no blanking gap every slot starts directly in SHOW.
  localparam state_t FIRST = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_t                        state, state_n;
  logic [CNT_W-1:0]              cnt, cnt_n;      // cycle within the current slot
  logic [IDX_W-1:0]              idx_n;
  logic                          boundary;        // next cycle is first of a frame
  logic                          commit;
  logic                          pending;
  logic [NUM_DIGITS-1:0][3:0]    act_dig, act_dig_n, shd_dig;
  logic [NUM_DIGITS-1:0]         act_dp, act_dp_n, shd_dp;
  logic [NUM_DIGITS-1:0]         lz;              // leading-zero suppression per digit

  // Slot sequencing. cnt runs across the whole slot; BLANK covers
  // 0..BLANK_CYCLES-1 and SHOW covers the rest.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = digit_idx;
    boundary = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n  = FIRST;
          cnt_n    = '0;
          idx_n    = '0;
          boundary = 1'b1;
        end
        BLANK: if (cnt == BLANK_END) state_n = SHOW;
        SHOW: if (cnt == SLOT_END) begin
          state_n = FIRST;
          cnt_n   = '0;
          if (digit_idx == LAST_IDX) begin
            idx_n    = '0;
            boundary = 1'b1;
          end else begin
            idx_n = digit_idx + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

  // Commit at the frame boundary. A request landing on the boundary cycle
  // bypasses the shadow and is committed directly.
  always_comb begin
    act_dig_n = act_dig;
    act_dp_n  = act_dp;
    commit    = 1'b0;
    if (boundary) begin
      if (update_req) begin
        act_dig_n = digits_in;
        act_dp_n  = dp_in;
        commit    = 1'b1;
      end else if (pending) begin
        act_dig_n = shd_dig;
        act_dp_n  = shd_dp;
        commit    = 1'b1;
      end
    end
  end

  // Evaluated on the value the active register will hold, so the
  // suppression pattern switches together with the digits at the boundary.
  always_comb begin
    lz = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      logic run;
      run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        run   = run & (act_dig_n[i] == 4'd0) & ~act_dp_n[i];
        lz[i] = run;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_idx  <= '0;
      act_dig    <= '0;
      act_dp     <= '0;
      shd_dig    <= '0;
      shd_dp     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      update_ack <= 1'b0;
      an         <= '1;
      bcd_out    <= 4'd0;
      dp_out     <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit_idx  <= idx_n;
      act_dig    <= act_dig_n;
      act_dp     <= act_dp_n;
      frame_done <= boundary;
      update_ack <= commit;
      if (update_req) begin
        shd_dig <= digits_in;
        shd_dp  <= dp_in;
      end
      // Every boundary drains whatever is pending (or the same-cycle request).
      pending <= boundary ? 1'b0 : (pending | update_req);

      an <= '1;
      if (state_n == SHOW && !blank_mask[idx_n] && !lz[idx_n])
        an[idx_n] <= 1'b0;
      // In BLANK the code is already presented so the decoder settles
      // before the anode turns on.
      if (state_n == IDLE) begin
        bcd_out <= 4'd0;
        dp_out  <= 1'b1;
      end else begin
        bcd_out <= act_dig_n[idx_n];
        dp_out  <= ~act_dp_n[idx_n];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Self-checking bench for seg7_scan_controller (4 digits, 8-cycle slots,
// 2-cycle blank). The reference model tracks the time elapsed since scanning
// started and derives slot, offset and frame boundaries arithmetically.
module tb_seg7_scan_controller;
  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = N * RD;

  logic          clk = 1'b0;
  logic          reset, enable, update_req;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]  dp_in, blank_mask;
  logic          update_ack, dp_out, frame_done;
  logic [3:0]    bcd_out;
  logic [N-1:0]  an;
  logic [1:0]    digit_idx;

  seg7_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .digits_in(digits_in),
    .dp_in(dp_in), .blank_mask(blank_mask), .update_req(update_req),
    .update_ack(update_ack), .bcd_out(bcd_out), .dp_out(dp_out), .an(an),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acks_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit       m_on;
  int       m_t;
  bit [3:0] m_dig [N];
  bit       m_dp  [N];
  bit [3:0] s_dig [N];
  bit       s_dp  [N];
  bit       m_pend;
  bit [N-1:0] e_an;
  bit [3:0] e_bcd;
  bit       e_dp, e_fd, e_ack;
  int       e_idx;

  function automatic bit lz_of(int s);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (s == 0) return 1'b0;
    for (int j = s; j < N; j++)
      if (m_dig[j] != 0 || m_dp[j]) return 1'b0;
    return 1'b1;
`else
    return (s < 0);
`endif
  endfunction

  task automatic model_edge();
    bit bnd;
    int slot, off;
    bnd = 1'b0;
    e_ack = 1'b0;
    if (reset) begin
      m_on = 0; m_t = 0; m_pend = 0;
      for (int i = 0; i < N; i++) begin
        m_dig[i] = 0; m_dp[i] = 0; s_dig[i] = 0; s_dp[i] = 0;
      end
      e_an = '1; e_bcd = 0; e_dp = 1; e_idx = 0; e_fd = 0;
      return;
    end
    if (!enable) m_on = 0;
    else begin
      if (!m_on) begin m_on = 1; m_t = 0; end
      else m_t++;
      bnd = (m_t % FRAME) == 0;
    end
    if (bnd) begin
      if (update_req) begin
        for (int i = 0; i < N; i++) begin m_dig[i] = digits_in[4*i +: 4]; m_dp[i] = dp_in[i]; end
        e_ack = 1;
      end else if (m_pend) begin
        for (int i = 0; i < N; i++) begin m_dig[i] = s_dig[i]; m_dp[i] = s_dp[i]; end
        e_ack = 1;
      end
      m_pend = 0;
    end else if (update_req) begin
      for (int i = 0; i < N; i++) begin s_dig[i] = digits_in[4*i +: 4]; s_dp[i] = dp_in[i]; end
      m_pend = 1;
    end
    e_fd = bnd;
    if (!m_on) begin
      e_an = '1; e_bcd = 0; e_dp = 1; e_idx = 0;
    end else begin
      slot = (m_t / RD) % N;
      off  = m_t % RD;
      e_idx = slot;
      e_bcd = m_dig[slot];
      e_dp  = ~m_dp[slot];
      e_an  = '1;
      if (off >= BC && !blank_mask[slot] && !lz_of(slot)) e_an[slot] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (update_ack) acks_seen++;
    chk("an", 32'(an), 32'(e_an));
    chk("bcd_out", 32'(bcd_out), 32'(e_bcd));
    chk("dp_out", 32'(dp_out), 32'(e_dp));
    chk("digit_idx", 32'(digit_idx), 32'(e_idx));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("update_ack", 32'(update_ack), 32'(e_ack));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model's frame position equals pos; bounded.
  task automatic align(input int pos);
    int k;
    k = 0;
    while (!(m_on && (m_t % FRAME) == pos) && k < 2 * FRAME) begin
      step();
      k++;
    end
    chk("align_timeout", 32'(m_on && (m_t % FRAME) == pos), 32'd1);
  endtask

  task automatic request(input logic [15:0] d, input logic [3:0] p);
    digits_in = d; dp_in = p; update_req = 1'b1;
    step();
    update_req = 1'b0;
  endtask

  initial begin
    reset = 1; enable = 0; update_req = 0; digits_in = '0; dp_in = '0; blank_mask = '0;
    cyc(2);
    reset = 0; enable = 1;
    cyc(70);

    // Update lands mid-slot 2; old digits stay until the boundary.
    align(19);
    request(16'h1234, 4'b0000);
    cyc(40);

    // Two back-to-back requests within one frame produce one ack.
    align(3);
    acks_seen = 0;
    request(16'h1111, 4'b0000);
    step();
    request(16'h5959, 4'b0000);
    cyc(36);
    chk("single_ack", 32'(acks_seen), 32'd1);

    // Masked digit stays dark.
    blank_mask = 4'b0100;
    cyc(64);
    blank_mask = 4'b0000;

    // Drop enable in SHOW of digit 1, then re-enable.
    align(12);
    enable = 0;
    step();
    chk("drop_an", 32'(an), 32'hF);
    chk("drop_idx", 32'(digit_idx), 32'd0);
    enable = 1;
    cyc(40);

    // Leading-zero patterns (fully shown when the feature is off).
    request(16'h0090, 4'b0000);
    cyc(70);
    request(16'h0090, 4'b1000);
    cyc(70);
    request(16'h0000, 4'b0000);
    cyc(40);

    // Random traffic, including rare resets and enable drops.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 499) == 0);
      enable     = ($urandom_range(0, 99) != 0);
      update_req = ($urandom_range(0, 19) == 0);
      digits_in  = 16'($urandom);
      dp_in      = 4'($urandom);
      if ($urandom_range(0, 199) == 0) blank_mask = 4'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
